// File: rtl/shift_saturate_if.sv
// Argument/result handshake bundle for shift_saturate.
interface shift_saturate_if #(
  parameter int ARGW = 16,
  parameter int RESW = ARGW,
  parameter int SHW  = 4
);
  logic            arg_stb;
  logic [ARGW-1:0] arg_dat;
  logic [SHW-1:0]  arg_sft;
  logic            arg_uns;
  logic            arg_rdy;
  logic            res_stb;
  logic [RESW-1:0] res_dat;
  logic            res_sat;
  logic            res_rdy;

  modport master (
    output arg_stb, arg_dat, arg_sft, arg_uns, res_rdy,
    input  arg_rdy, res_stb, res_dat, res_sat
  );

  modport slave (
    input  arg_stb, arg_dat, arg_sft, arg_uns, res_rdy,
    output arg_rdy, res_stb, res_dat, res_sat
  );
endinterface

// File: rtl/shift_saturate.sv
// Two-stage right-shift / saturate pipeline with a sticky saturation-event counter.
// Define SHIFT_SATURATE_ROUND_EN to round half toward +inf instead of truncating.
module shift_saturate #(
  parameter int ARGW = 16,
  parameter int RESW = ARGW,
  parameter int SHW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  shift_saturate_if.slave bus,
  input  logic            sat_clr,
  output logic [CNTW-1:0] sat_cnt
);
  localparam int W = ARGW + 2;

  localparam logic signed [W-1:0] SMAX = {{(W-RESW+1){1'b0}}, {(RESW-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {{(W-RESW+1){1'b1}}, {(RESW-1){1'b0}}};
  localparam logic signed [W-1:0] UMAX = {{(W-RESW){1'b0}}, {RESW{1'b1}}};

  generate
    if (RESW > ARGW) begin : g_bad_resw
      $error("ERROR: shift_saturate RESW (%0d) exceeds ARGW (%0d)", RESW, ARGW);
    end
  endgenerate

  logic                s1_vld = 1'b0;
  logic signed [W-1:0] s1_val = '0;
  logic                s1_uns = 1'b0;
  logic                res_stb_q = 1'b0;
  logic [RESW-1:0]     res_dat_q = '0;
  logic                res_sat_q = 1'b0;
  logic [CNTW-1:0]     sat_cnt_q = '0;

  logic                advance;
  logic                arg_rdy;
  logic signed [W-1:0] ext;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] shf;
  logic [RESW-1:0]     c_dat;
  logic                c_sat;

  assign advance = ~res_stb_q | bus.res_rdy;
  assign arg_rdy = ~s1_vld | advance;

  assign ext = bus.arg_uns ? {2'b00, bus.arg_dat}
                           : {{2{bus.arg_dat[ARGW-1]}}, bus.arg_dat};

`ifdef SHIFT_SATURATE_ROUND_EN
  // Half an output LSB; shifting the one back down makes it vanish for sft=0.
  logic [W-1:0] rnd;
  assign rnd = ({{(W-1){1'b0}}, 1'b1} << bus.arg_sft) >> 1;
  assign sum = ext + $signed(rnd);
`else
  assign sum = ext;
`endif

  // Two guard bits keep the unsigned sum positive, so >>> would also be correct there.
  assign shf = bus.arg_uns ? (sum >> bus.arg_sft) : (sum >>> bus.arg_sft);

  always_comb begin
    c_dat = s1_val[RESW-1:0];
    c_sat = 1'b0;
    if (s1_uns) begin
      if (s1_val > UMAX) begin
        c_dat = '1;
        c_sat = 1'b1;
      end
    end else if (s1_val > SMAX) begin
      c_dat = {1'b0, {(RESW-1){1'b1}}};
      c_sat = 1'b1;
    end else if (s1_val < SMIN) begin
      c_dat = {1'b1, {(RESW-1){1'b0}}};
      c_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_val <= '0;
      s1_uns <= 1'b0;
    end else if (arg_rdy) begin
      s1_vld <= bus.arg_stb;
      if (bus.arg_stb) begin
        s1_val <= shf;
        s1_uns <= bus.arg_uns;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_stb_q <= 1'b0;
      res_dat_q <= '0;
      res_sat_q <= 1'b0;
    end else if (advance) begin
      res_stb_q <= s1_vld;
      if (s1_vld) begin
        res_dat_q <= c_dat;
        res_sat_q <= c_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_cnt_q <= '0;
    end else if (res_stb_q && bus.res_rdy && res_sat_q && (sat_cnt_q != {CNTW{1'b1}})) begin
      sat_cnt_q <= sat_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign bus.arg_rdy = arg_rdy;
  assign bus.res_stb = res_stb_q;
  assign bus.res_dat = res_dat_q;
  assign bus.res_sat = res_sat_q;
  assign sat_cnt     = sat_cnt_q;
endmodule

// File: tb/tb_shift_saturate.sv
// Bench for shift_saturate (ARGW=16, RESW=8, SHW=4, CNTW=2): directed corner cases
// plus randomized traffic against a floor-division/clamp reference model.
module tb_shift_saturate;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sat_clr = 1'b0;
  logic [1:0] sat_cnt;

  shift_saturate_if #(.ARGW(16), .RESW(8), .SHW(4)) bus ();

  shift_saturate #(.ARGW(16), .RESW(8), .SHW(4), .CNTW(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cnt_m = 0;
  logic       held_v = 1'b0;
  logic [7:0] held_d = '0;
  logic       held_s = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  function automatic exp_t ref_model(input logic [15:0] a, input logic [3:0] s, input logic u);
    longint v, p, q, lo, hi;
    exp_t   r;
    v = u ? longint'(a) : longint'($signed(a));
`ifdef SHIFT_SATURATE_ROUND_EN
    if (s != 0) v = v + (longint'(1) << (s - 1));
`endif
    p = longint'(1) << s;
    q = v / p;
    if ((v % p != 0) && (v < 0)) q = q - 1;
    lo = u ? 0 : -128;
    hi = u ? 255 : 127;
    r.s = 1'b1;
    if (q > hi)      q = hi;
    else if (q < lo) q = lo;
    else             r.s = 1'b0;
    r.d = q[7:0];
    return r;
  endfunction

  task automatic cyc(input logic stb, input logic [15:0] d, input logic [3:0] s, input logic u,
                     input logic rdy, input logic clr, input logic use_x, input logic [7:0] xd,
                     input logic xs, output logic acc);
    exp_t e;
    logic hs;
    logic hs_sat;
    @(negedge clk);
    bus.arg_stb = stb;
    bus.arg_dat = d;
    bus.arg_sft = s;
    bus.arg_uns = u;
    bus.res_rdy = rdy;
    sat_clr     = clr;
    #2;
    acc = 1'b0;
    hs = 1'b0;
    hs_sat = 1'b0;
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
      cnt_m  = 0;
    end else begin
      if (held_v) begin
        chk("hold_stb", {31'd0, bus.res_stb}, 32'd1);
        chk("hold_dat", {24'd0, bus.res_dat}, {24'd0, held_d});
        chk("hold_sat", {31'd0, bus.res_sat}, {31'd0, held_s});
      end
      held_v = 1'b0;
      if (bus.res_stb) begin
        if (bus.res_rdy) begin
          if (exp_q.size() == 0) begin
            chk("spurious_res", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("res_dat", {24'd0, bus.res_dat}, {24'd0, e.d});
            chk("res_sat", {31'd0, bus.res_sat}, {31'd0, e.s});
            hs = 1'b1;
            hs_sat = e.s;
          end
        end else begin
          held_v = 1'b1;
          held_d = bus.res_dat;
          held_s = bus.res_sat;
        end
      end
      if (stb && bus.arg_rdy) begin
        acc = 1'b1;
        if (use_x) begin
          e.d = xd;
          e.s = xs;
        end else begin
          e = ref_model(d, s, u);
        end
        exp_q.push_back(e);
      end
      if (clr) cnt_m = 0;
      else if (hs && hs_sat && cnt_m < 3) cnt_m++;
    end
    @(posedge clk);
    #1;
    chk("sat_cnt", {30'd0, sat_cnt}, cnt_m);
  endtask

  task automatic idle(input logic rdy);
    logic a;
    cyc(1'b0, 16'h0, 4'h0, 1'b0, rdy, 1'b0, 1'b0, 8'h0, 1'b0, a);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.res_stb) && n < 20) begin
      idle(1'b1);
      n++;
    end
    if (n >= 20) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic dir(input string tag, input logic [15:0] d, input logic [3:0] s, input logic u,
                     input logic [7:0] xd, input logic xs);
    logic a = 1'b0;
    int   n = 0;
    while (!a && n < 10) begin
      cyc(1'b1, d, s, u, 1'b1, 1'b0, 1'b1, xd, xs, a);
      n++;
    end
    if (!a) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    drain();
  endtask

  logic [15:0] st_args[3];
  int          idx;
  int          n;
  logic        a;

  initial begin
    bus.arg_stb = 1'b0;
    bus.arg_dat = '0;
    bus.arg_sft = '0;
    bus.arg_uns = 1'b0;
    bus.res_rdy = 1'b0;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    chk("rst_arg_rdy", {31'd0, bus.arg_rdy}, 32'd1);
    chk("rst_res_stb", {31'd0, bus.res_stb}, 32'd0);
    chk("rst_res_dat", {24'd0, bus.res_dat}, 32'd0);
    chk("rst_res_sat", {31'd0, bus.res_sat}, 32'd0);
    chk("rst_sat_cnt", {30'd0, sat_cnt}, 32'd0);

    dir("s_pos_clamp", 16'h0100, 4'd0, 1'b0, 8'h7F, 1'b1);
    chk("sat_cnt_one", {30'd0, sat_cnt}, 32'd1);
    dir("s_neg_clamp", 16'hFF00, 4'd0, 1'b0, 8'h80, 1'b1);
    chk("sat_cnt_two", {30'd0, sat_cnt}, 32'd2);
`ifdef SHIFT_SATURATE_ROUND_EN
    dir("s_round", 16'hFFF8, 4'd4, 1'b0, 8'h00, 1'b0);
`else
    dir("s_trunc", 16'hFFF8, 4'd4, 1'b0, 8'hFF, 1'b0);
`endif
    dir("u_clamp", 16'h0123, 4'd0, 1'b1, 8'hFF, 1'b1);
    dir("u_pass",  16'h0042, 4'd0, 1'b1, 8'h42, 1'b0);
`ifdef SHIFT_SATURATE_ROUND_EN
    dir("u_round_ovf", 16'hFFFF, 4'd8, 1'b1, 8'hFF, 1'b1);
`else
    dir("u_shift8", 16'hFFFF, 4'd8, 1'b1, 8'hFF, 1'b0);
`endif

    // Backpressure: only two arguments fit while the output is stalled.
    st_args[0] = 16'h0011;
    st_args[1] = 16'h0022;
    st_args[2] = 16'h0033;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(idx < 3, st_args[idx % 3], 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, a);
      if (a) idx++;
    end
    chk("stall_accepts", idx, 32'd2);
    n = 0;
    while (idx < 3 && n < 10) begin
      cyc(1'b1, st_args[idx], 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b0, a);
      if (a) idx++;
      n++;
    end
    chk("stall_third_accept", idx, 32'd3);
    drain();

    // Reset with both stages full discards the in-flight data.
    cyc(1'b1, 16'h0100, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, a);
    cyc(1'b1, 16'h0200, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, a);
    idle(1'b0);
    chk("full_before_rst", {31'd0, bus.arg_rdy}, 32'd0);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    chk("rst_flush_stb", {31'd0, bus.res_stb}, 32'd0);
    chk("rst_flush_rdy", {31'd0, bus.arg_rdy}, 32'd1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Counter sticks at 3; clear wins over a concurrent saturated handshake.
    for (int i = 0; i < 4; i++) dir("cnt_sat", 16'h7FFF, 4'd0, 1'b0, 8'h7F, 1'b1);
    chk("cnt_sticky", {30'd0, sat_cnt}, 32'd3);
    cyc(1'b1, 16'h8000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, a);
    idle(1'b0);
    idle(1'b0);
    cyc(1'b0, 16'h0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0, 1'b0, a);
    chk("cnt_clr_priority", {30'd0, sat_cnt}, 32'd0);
    drain();

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
          1'b0, 8'h0, 1'b0, a);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
